ikaopll_acc_i2s_reader: RTL and testbench

Consumer of the DAC block's accumulated 16-bit signed output: captures each sample on the rising edge of the accumulator strobe, buffers it in a small FIFO, and serializes it as a mono-duplicated I2S stream for an external audio codec. It sits between the DAC block and the top-level audio pins, decoupling the chip's sample cadence from the codec bit clock. Sticky flags report cadence mismatch, overflow and underrun.

---
 rtl/ikaopll_acc_i2s_reader.sv | 149 ++++++++++++++
 tb/tb_ikaopll_acc_i2s_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_acc_i2s_reader.sv
// Captures the DAC accumulator sample on each strobe rising edge, queues it in a small FIFO and
// serializes it as a mono-duplicated 16-bit-per-channel I2S stream with sticky cadence flags.
module ikaopll_acc_i2s_reader #(
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        i_EMUCLK,
    input  logic                        i_RST,
    input  logic                        i_ACC_SIGNED_STRB,
    input  logic [15:0]                 i_ACC_SIGNED,
    input  logic                        i_TX_EN,
    input  logic                        i_FLAG_CLR,
    output logic                        o_I2S_BCLK,
    output logic                        o_I2S_LRCK,
    output logic                        o_I2S_SDATA,
    output logic [$clog2(FIFO_DEPTH):0] o_FIFO_LEVEL,
    output logic                        o_OVERFLOW,
    output logic                        o_UNDERRUN
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_TC   = DW'(BCLK_DIV - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    // capture and FIFO state
    logic          strb_z;
    logic          seen_q;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [15:0]   last_q;

    // serializer state
    logic [DW-1:0] div_q;
    logic          bclk_q;
    logic [4:0]    slot_q;
    logic [31:0]   shift_q;
    logic          lrck_q;
    logic          sdata_q;

    logic          ovf_q;
    logic          udr_q;

    logic          push_req;
    logic          fifo_empty;
    logic          fifo_full;
    logic          bclk_fall;
    logic          pop_point;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic          udr_set;
    logic [15:0]   rd_data;
    logic [4:0]    slot_d;
    logic [31:0]   shift_d;

    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        push_req   = i_ACC_SIGNED_STRB & ~strb_z;
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_FULL);
        bclk_fall  = i_TX_EN & bclk_q & (div_q == DIV_TC);
        pop_point  = bclk_fall & (slot_q == 5'd31);
        pop        = pop_point & ~fifo_empty;
        // a pop frees the slot in the same cycle, so a full FIFO still accepts the push
        push       = push_req & (~fifo_full | pop);
        ovf_set    = push_req & fifo_full & ~pop;
        udr_set    = pop_point & fifo_empty & seen_q;
        slot_d     = slot_q + 5'd1;
        if (pop_point) begin
            shift_d = fifo_empty ? {last_q, last_q} : {rd_data, rd_data};
        end else begin
            shift_d = {shift_q[30:0], 1'b0};
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            strb_z   <= 1'b0;
            seen_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            div_q    <= '0;
            bclk_q   <= 1'b0;
            slot_q   <= 5'd31;
            shift_q  <= '0;
            lrck_q   <= 1'b0;
            sdata_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udr_q    <= 1'b0;
        end else begin
            strb_z <= i_ACC_SIGNED_STRB;

            if (push) begin
                mem_q[wr_ptr_q] <= i_ACC_SIGNED;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
                seen_q          <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= rd_data;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase

            // set events take priority over a simultaneous clear
            ovf_q <= ovf_set | (ovf_q & ~i_FLAG_CLR);
            udr_q <= udr_set | (udr_q & ~i_FLAG_CLR);

            if (!i_TX_EN) begin
                div_q   <= '0;
                bclk_q  <= 1'b0;
                slot_q  <= 5'd31;
                lrck_q  <= 1'b0;
                sdata_q <= 1'b0;
            end else if (div_q == DIV_TC) begin
                div_q  <= '0;
                bclk_q <= ~bclk_q;
                if (bclk_q) begin
                    slot_q  <= slot_d;
                    shift_q <= shift_d;
                    sdata_q <= shift_d[31];
                    lrck_q  <= (slot_d >= 5'd15) && (slot_d <= 5'd30);
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign o_I2S_BCLK   = bclk_q;
    assign o_I2S_LRCK   = lrck_q;
    assign o_I2S_SDATA  = sdata_q;
    assign o_FIFO_LEVEL = level_q;
    assign o_OVERFLOW   = ovf_q;
    assign o_UNDERRUN   = udr_q;

endmodule

// File: tb/tb_ikaopll_acc_i2s_reader.sv
// Directed bench: stimulus queues expected frame samples, an I2S deserializing monitor checks them.
module tb_ikaopll_acc_i2s_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        strb;
    logic [15:0] data;
    logic        tx_en;
    logic        flag_clr;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic [2:0]  level;
    logic        ovf;
    logic        udr;

    int checks = 0;
    int passed = 0;
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    ikaopll_acc_i2s_reader #(
        .BCLK_DIV   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .i_EMUCLK          (clk),
        .i_RST             (rst),
        .i_ACC_SIGNED_STRB (strb),
        .i_ACC_SIGNED      (data),
        .i_TX_EN           (tx_en),
        .i_FLAG_CLR        (flag_clr),
        .o_I2S_BCLK        (bclk),
        .o_I2S_LRCK        (lrck),
        .o_I2S_SDATA       (sdata),
        .o_FIFO_LEVEL      (level),
        .o_OVERFLOW        (ovf),
        .o_UNDERRUN        (udr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic edge_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_bclk"}, 32'(bclk), 32'd0);
        chk({tag, "_lrck"}, 32'(lrck), 32'd0);
        chk({tag, "_sdata"}, 32'(sdata), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_udr"}, 32'(udr), 32'd0);
    endtask

    // Monitor: rebuild 32-slot frames from BCLK rises; first rise after (re)start is the lead-in slot 31
    int          bitcnt = -1;
    logic        bclk_prev = 1'b0;
    logic [31:0] data_w = '0;
    logic [31:0] lr_w = '0;
    logic [15:0] exp_s;

    always @(negedge clk) begin
        if (rst || !tx_en) begin
            bitcnt    = -1;
            bclk_prev = 1'b0;
        end else begin
            if (bclk && !bclk_prev) begin
                if (bitcnt < 0) begin
                    bitcnt = 0;
                end else begin
                    data_w = {data_w[30:0], sdata};
                    lr_w   = {lr_w[30:0], lrck};
                    bitcnt++;
                    if (bitcnt == 32) begin
                        bitcnt = 0;
                        if (sb.size() == 0) begin
                            checks++;
                            $display("FAIL frame_extra: got 0x%08h, want no frame", data_w);
                        end else begin
                            exp_s = sb.pop_front();
                            chk("frame_data", data_w, {exp_s, exp_s});
                            chk("frame_lrck", lr_w, 32'h0001_fffe);
                        end
                    end
                end
            end
            bclk_prev = bclk;
        end
    end

    logic [15:0] burst [5];

    initial begin
        rst      = 1'b1;
        strb     = 1'b0;
        data     = '0;
        tx_en    = 1'b0;
        flag_clr = 1'b0;
        edge_n(3);
        chk_idle("reset");
        rst = 1'b0;

        // single sample 0x8001 with the serializer running; second frame underruns
        sb.push_back(16'h8001);
        sb.push_back(16'h8001);
        tx_en = 1'b1;
        strb  = 1'b1;
        data  = 16'h8001;
        edge_n(1);
        chk("p1_level_push", 32'(level), 32'd1);
        edge_n(2);
        strb = 1'b0;
        edge_n(5);
        chk("p1_level_pop", 32'(level), 32'd0);
        chk("p1_msb", 32'(sdata), 32'd1);
        chk("p1_lrck_slot0", 32'(lrck), 32'd0);
        edge_n(200);
        chk("p1_udr_early", 32'(udr), 32'd0);
        edge_n(60);
        chk("p1_udr_late", 32'(udr), 32'd1);
        edge_n(300);
        tx_en = 1'b0;

        // long strobe yields exactly one push
        edge_n(3);
        chk("p2_level_before", 32'(level), 32'd0);
        strb = 1'b1;
        data = 16'h1234;
        for (int i = 0; i < 20; i++) begin
            edge_n(1);
            chk("p2_level_held", 32'(level), 32'd1);
        end
        strb = 1'b0;
        edge_n(2);

        rst = 1'b1;
        edge_n(2);
        rst = 1'b0;
        chk("rst2_level", 32'(level), 32'd0);
        chk("rst2_udr", 32'(udr), 32'd0);
        chk("rst2_ovf", 32'(ovf), 32'd0);

        // five strobes into a depth-4 FIFO with the serializer off
        burst[0] = 16'h7fff;
        burst[1] = 16'h8000;
        burst[2] = 16'hffff;
        burst[3] = 16'h0001;
        burst[4] = 16'h5a5a;
        for (int i = 0; i < 5; i++) begin
            strb = 1'b1;
            data = burst[i];
            edge_n(3);
            strb = 1'b0;
            edge_n(3);
            if (i == 3) begin
                chk("p3_level_full", 32'(level), 32'd4);
                chk("p3_ovf_before", 32'(ovf), 32'd0);
            end
        end
        chk("p3_level_sat", 32'(level), 32'd4);
        chk("p3_ovf_set", 32'(ovf), 32'd1);
        for (int i = 0; i < 4; i++) sb.push_back(burst[i]);
        sb.push_back(16'h6b6b);
        sb.push_back(16'h6b6b);
        sb.push_back(16'h6b6b);

        flag_clr = 1'b1;
        edge_n(1);
        flag_clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);

        // full FIFO with a strobe edge on the first pop cycle
        tx_en = 1'b1;
        edge_n(7);
        chk("p4_level_prepop", 32'(level), 32'd4);
        strb = 1'b1;
        data = 16'h6b6b;
        edge_n(1);
        chk("p4_level_pushpop", 32'(level), 32'd4);
        chk("p4_ovf_clear", 32'(ovf), 32'd0);
        chk("p4_msb", 32'(sdata), 32'd0);
        edge_n(3);
        strb = 1'b0;

        // underrun, isolated clear, clear coinciding with a new underrun, isolated clear
        edge_n(1290);
        chk("p5_udr_set", 32'(udr), 32'd1);
        flag_clr = 1'b1;
        edge_n(1);
        flag_clr = 1'b0;
        chk("p5_udr_cleared", 32'(udr), 32'd0);
        edge_n(241);
        flag_clr = 1'b1;
        edge_n(1);
        flag_clr = 1'b0;
        chk("p5_udr_set_wins", 32'(udr), 32'd1);
        edge_n(10);
        flag_clr = 1'b1;
        edge_n(1);
        flag_clr = 1'b0;
        chk("p5_clr_udr", 32'(udr), 32'd0);
        chk("p5_clr_ovf", 32'(ovf), 32'd0);

        // queue three samples, then reset in slot 20 while BCLK is high
        edge_n(256);
        strb = 1'b1; data = 16'h0f0f; edge_n(3);
        strb = 1'b0; edge_n(3);
        strb = 1'b1; data = 16'hf0f0; edge_n(3);
        strb = 1'b0; edge_n(3);
        strb = 1'b1; data = 16'h1357; edge_n(3);
        strb = 1'b0;
        chk("p6_level_queued", 32'(level), 32'd3);
        edge_n(138);
        rst = 1'b1;
        edge_n(1);
        rst = 1'b0;
        chk_idle("p6_reset");

        sb.push_back(16'h2468);
        strb = 1'b1;
        data = 16'h2468;
        edge_n(1);
        chk("p6_level_new", 32'(level), 32'd1);
        edge_n(2);
        strb = 1'b0;
        edge_n(300);
        tx_en = 1'b0;

        for (int i = 0; i < 500 && sb.size() != 0; i++) edge_n(1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
